// File: rtl/alu_4bit_if.sv
// rtl/alu_4bit_if.sv - operand/result bundle for the registered ALU
//
// Purpose: groups the ALU request (valid, operands, opcode, carry-in) and
// the registered response (result, flags, valid) into one connection.
// Ports (signals):
//   in_valid, operand1[WIDTH], operand2[WIDTH], opcode[3], cin  : request
//   result[WIDTH], cout, zero, overflow, out_valid              : response
// Modports: master drives the request, slave (the ALU) drives the response.
interface alu_4bit_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [2:0]       opcode;
    logic             cin;
    logic [WIDTH-1:0] result;
    logic             cout;
    logic             zero;
    logic             overflow;
    logic             out_valid;

    modport master (
        output in_valid, operand1, operand2, opcode, cin,
        input  result, cout, zero, overflow, out_valid
    );

    modport slave (
        input  in_valid, operand1, operand2, opcode, cin,
        output result, cout, zero, overflow, out_valid
    );
endinterface

// File: rtl/alu_4bit.sv
// rtl/alu_4bit.sv - registered 4-bit ALU execute stage with carry and flags
//
// Purpose: samples operands/opcode/cin when in_valid is high and presents the
// result with carry, zero and overflow flags one clock later.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears all outputs
//   bus    : alu_4bit_if.slave (request in, registered response out)
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NOT, 110 SHL, 111 SHR
module alu_4bit #(
    parameter int WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    alu_4bit_if.slave   bus
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] nxt_result;
    logic             nxt_cout;
    logic             nxt_overflow;

    always_comb begin
        sum          = '0;
        nxt_result   = '0;
        nxt_cout     = 1'b0;
        nxt_overflow = 1'b0;
        case (bus.opcode)
            OP_ADD: begin
                sum          = {1'b0, bus.operand1} + {1'b0, bus.operand2}
                             + {{WIDTH{1'b0}}, bus.cin};
                nxt_result   = sum[WIDTH-1:0];
                nxt_cout     = sum[WIDTH];
                nxt_overflow = (bus.operand1[MSB] == bus.operand2[MSB])
                            && (sum[MSB] != bus.operand1[MSB]);
            end
            OP_SUB: begin
                // a - b - cin as a + ~b + ~cin; carry out of that sum is the
                // inverted borrow (1 = no borrow).
                sum          = {1'b0, bus.operand1} + {1'b0, ~bus.operand2}
                             + {{WIDTH{1'b0}}, ~bus.cin};
                nxt_result   = sum[WIDTH-1:0];
                nxt_cout     = sum[WIDTH];
                nxt_overflow = (bus.operand1[MSB] != bus.operand2[MSB])
                            && (sum[MSB] != bus.operand1[MSB]);
            end
            OP_AND: nxt_result = bus.operand1 & bus.operand2;
            OP_OR:  nxt_result = bus.operand1 | bus.operand2;
            OP_XOR: nxt_result = bus.operand1 ^ bus.operand2;
            OP_NOT: nxt_result = ~bus.operand1;
            OP_SHL: begin
                nxt_result = {bus.operand1[WIDTH-2:0], bus.cin};
                nxt_cout   = bus.operand1[MSB];
            end
            OP_SHR: begin
                nxt_result = {bus.cin, bus.operand1[WIDTH-1:1]};
                nxt_cout   = bus.operand1[0];
            end
            default: begin
                nxt_result = '0;
            end
        endcase
    end

    // Flags and result only move on a valid strobe; out_valid marks the
    // cycle in which they were refreshed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result    <= '0;
            bus.cout      <= 1'b0;
            bus.zero      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.result   <= nxt_result;
                bus.cout     <= nxt_cout;
                bus.zero     <= (nxt_result == '0);
                bus.overflow <= nxt_overflow;
            end
        end
    end
endmodule

// File: tb/tb_alu_4bit.sv
// tb/tb_alu_4bit.sv - self-checking bench for alu_4bit
module tb_alu_4bit;
    logic clk;
    logic rst_n;

    alu_4bit_if #(.WIDTH(4)) bus ();

    alu_4bit #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] res;
        logic       cout;
        logic       zero;
        logic       ovf;
    } res_t;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic       c;
        res_t       exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference computed with signed/unsigned integer arithmetic.
    function automatic res_t model(input logic [2:0] op, input logic [3:0] a,
                                   input logic [3:0] b, input logic c);
        int ua, ub, ci, sa, sb, s, ss;
        res_t r;
        ua = int'(a); ub = int'(b); ci = c ? 1 : 0;
        sa = (ua >= 8) ? ua - 16 : ua;
        sb = (ub >= 8) ? ub - 16 : ub;
        r = '0;
        case (op)
            3'd0: begin
                s = ua + ub + ci; ss = sa + sb + ci;
                r.res = 4'(s); r.cout = (s > 15); r.ovf = (ss > 7) || (ss < -8);
            end
            3'd1: begin
                s = ua - ub - ci; ss = sa - sb - ci;
                r.res = 4'(s); r.cout = (s >= 0); r.ovf = (ss > 7) || (ss < -8);
            end
            3'd2: r.res = a & b;
            3'd3: r.res = a | b;
            3'd4: r.res = a ^ b;
            3'd5: r.res = 4'(15 - ua);
            3'd6: begin r.res = 4'((ua * 2 + ci) % 16); r.cout = (ua >= 8); end
            default: begin r.res = 4'(ci * 8 + ua / 2); r.cout = (ua % 2 == 1); end
        endcase
        r.zero = (r.res == 4'd0);
        return r;
    endfunction

    function automatic vec_t mk(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                input logic c, input logic [3:0] res, input logic co,
                                input logic z, input logic ov);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.c = c;
        v.exp.res = res; v.exp.cout = co; v.exp.zero = z; v.exp.ovf = ov;
        return v;
    endfunction

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a,
                         input logic [3:0] b, input logic c);
        bus.in_valid = v; bus.opcode = op; bus.operand1 = a; bus.operand2 = b; bus.cin = c;
    endtask

    task automatic check_out(input string tag, input res_t e, input logic v);
        check({tag, " result"},    int'(bus.result),    int'(e.res));
        check({tag, " cout"},      int'(bus.cout),      int'(e.cout));
        check({tag, " zero"},      int'(bus.zero),      int'(e.zero));
        check({tag, " overflow"},  int'(bus.overflow),  int'(e.ovf));
        check({tag, " out_valid"}, int'(bus.out_valid), int'(v));
    endtask

    vec_t vecs[13];
    res_t zero_r;
    res_t exp_r;
    logic exp_v;

    initial begin
        vecs[0]  = mk(3'b000, 4'b0101, 4'b0011, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1);
        vecs[1]  = mk(3'b000, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b0);
        vecs[2]  = mk(3'b000, 4'b0111, 4'b0000, 1'b1, 4'b1000, 1'b0, 1'b0, 1'b1);
        vecs[3]  = mk(3'b001, 4'b0101, 4'b0011, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0);
        vecs[4]  = mk(3'b001, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0);
        vecs[5]  = mk(3'b001, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(3'b001, 4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b1, 1'b0, 1'b0);
        vecs[7]  = mk(3'b010, 4'b0101, 4'b0011, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(3'b011, 4'b0101, 4'b0011, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
        vecs[9]  = mk(3'b100, 4'b0101, 4'b0011, 1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        vecs[10] = mk(3'b101, 4'b0101, 4'b0011, 1'b1, 4'b1010, 1'b0, 1'b0, 1'b0);
        vecs[11] = mk(3'b110, 4'b1001, 4'b0000, 1'b1, 4'b0011, 1'b1, 1'b0, 1'b0);
        vecs[12] = mk(3'b111, 4'b1001, 4'b0000, 1'b1, 4'b1100, 1'b1, 1'b0, 1'b0);
        zero_r = '0;

        rst_n = 1'b0;
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        repeat (2) @(negedge clk);
        check_out("reset", zero_r, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("idle after reset", zero_r, 1'b0);

        // Table vectors streamed back to back, one result per cycle.
        for (int i = 0; i < 13; i++) begin
            drive(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
            @(negedge clk);
            check_out($sformatf("vec%0d", i), vecs[i].exp, 1'b1);
        end
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        check_out("hold after drop", vecs[12].exp, 1'b0);

        // Randomized stream with gaps against the reference model.
        exp_r = vecs[12].exp;
        for (int i = 0; i < 300; i++) begin
            logic v;
            logic [2:0] op;
            logic [3:0] a, b;
            logic c;
            v  = ($urandom_range(0, 3) != 0);
            op = 3'($urandom_range(0, 7));
            a  = 4'($urandom_range(0, 15));
            b  = 4'($urandom_range(0, 15));
            c  = 1'($urandom_range(0, 1));
            drive(v, op, a, b, c);
            if (v) exp_r = model(op, a, b, c);
            exp_v = v;
            @(negedge clk);
            check_out($sformatf("rand%0d op%0d a%0d b%0d c%0d", i, op, a, b, c), exp_r, exp_v);
        end

        // Reset asserted mid-stream clears outputs at once and drops the op in flight.
        drive(1'b1, 3'b000, 4'b0101, 4'b0011, 1'b0);
        @(posedge clk);
        #2;
        check("pre-reset result", int'(bus.result), 8);
        rst_n = 1'b0;
        #1;
        check_out("async reset", zero_r, 1'b0);
        @(negedge clk);
        check_out("reset holds over valid edge", zero_r, 1'b0);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        check_out("release idle", zero_r, 1'b0);
        drive(1'b1, 3'b001, 4'b0101, 4'b0011, 1'b0);
        @(negedge clk);
        check_out("first after release", vecs[3].exp, 1'b1);
        drive(1'b0, 3'b000, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        check_out("final hold", vecs[3].exp, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
